// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Assembles little-endian UART bytes into 32-bit words and writes
//            them to consecutive instruction-memory addresses until ECALL.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_err_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  localparam int                  MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_WORDS - 1);
  localparam logic [31:0]         ECALL     = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_buf_q, word_buf_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, busy_q, done_q, err_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    word_buf_d = word_buf_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_LOAD;
          byte_idx_d = 2'd0;
          addr_d     = '0;
          count_d    = '0;
        end
      end
      S_LOAD: begin
        if (rx_valid_i) begin
          word_buf_d[{byte_idx_q, 3'b000} +: 8] = rx_byte_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + (ADDR_WIDTH + 1)'(1);
        if (word_buf_q == ECALL) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_ERROR;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_LOAD;
          // A byte arriving alongside the write starts the next word.
          if (rx_valid_i) begin
            word_buf_d[7:0] = rx_byte_i;
            byte_idx_d      = 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      addr_q     <= '0;
      word_buf_q <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      word_buf_q <= word_buf_d;
      count_q    <= count_d;
      we_q       <= (state_d == S_WRITE);
      busy_q     <= (state_d == S_LOAD) || (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERROR);
    end
  end

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = word_buf_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overflow_err_o = err_q;
  assign word_count_o   = count_q;

endmodule
`default_nettype wire
